// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers.
// Stages the winning word in a register and holds it while the FIFO is full.
module fifo_write_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 32,
  parameter int CW   = 16,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               clr_cnt,
  input  logic               fifo_FULL,
  output logic               fifo_WR,
  output logic               fifo_EN,
  output logic [DW-1:0]      fifo_dataIn,
  output logic [IW-1:0]      grant_id,
  output logic [NREQ*CW-1:0] accept_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PUSH  = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          wr_q, wr_d;
  logic          en_q, en_d;
  logic [DW-1:0] data_q, data_d;
  logic [IW-1:0] gid_q, gid_d;
  logic [IW-1:0] last_q, last_d;
  logic [CW-1:0] cnt_q [NREQ];
  logic [CW-1:0] cnt_d [NREQ];

  logic          win_found;
  logic [IW-1:0] win_idx;
  logic          can_load;
  logic          hs;

  // Search starts just past the last grant and wraps modulo NREQ.
  always_comb begin
    int idx;
    logic [IW-1:0] idx_w;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    idx_w     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx   = (int'(last_q) + k) % NREQ;
      idx_w = IW'(idx);
      if (!win_found && req_valid[idx_w]) begin
        win_found = 1'b1;
        win_idx   = idx_w;
      end
    end
  end

  assign can_load = (state_q == S_IDLE) | (wr_q & ~fifo_FULL);
  assign hs       = Rst & can_load & win_found;

  always_comb begin
    req_ready = '0;
    if (hs) begin
      req_ready[win_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    data_d  = data_q;
    gid_d   = gid_q;
    last_d  = last_q;
    en_d    = 1'b1;
    if (hs) begin
      state_d = S_PUSH;
      wr_d    = 1'b1;
      data_d  = req_data[int'(win_idx)*DW +: DW];
      gid_d   = win_idx;
      last_d  = win_idx;
    end else if (state_q != S_IDLE) begin
      if (fifo_FULL) begin
        state_d = S_STALL;
      end else begin
        state_d = S_IDLE;
        wr_d    = 1'b0;
      end
    end
  end

  // Clear takes priority so a same-cycle handshake is not counted.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr_cnt) begin
        cnt_d[i] = '0;
      end else if (hs && win_idx == IW'(i) && cnt_q[i] != '1) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      en_q    <= 1'b0;
      data_q  <= '0;
      gid_q   <= '0;
      last_q  <= IW'(NREQ - 1);
      for (int i = 0; i < NREQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      en_q    <= en_d;
      data_q  <= data_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
      for (int i = 0; i < NREQ; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign fifo_WR     = wr_q;
  assign fifo_EN     = en_q;
  assign fifo_dataIn = data_q;
  assign grant_id    = gid_q;

  for (genvar g = 0; g < NREQ; g++) begin : g_cnt
    assign accept_cnt[g*CW +: CW] = cnt_q[g];
  end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin write arbiter that shares one 32-bit FIFObuffer write port among NREQ independent producers. It accepts words from producers over a valid/ready handshake and stages the winning word in an output register. It drives the FIFO's WR/EN/dataIn and holds the staged word while the FIFO reports FULL. Per-producer accepted-word counters are provided for debug and throughput checks.

## Interface
- NREQ, 4: number of producers (2..8)
- DW, 32: data width; matches FIFObuffer dataIn
- CW, 16: width of each accepted-word counter
- IW, $clog2(NREQ): width of grant_id
- Clk  in  1  clock; all logic on posedge
- Rst  in  1  synchronous, active-low reset (Rst=0 resets on the next posedge)
- req_valid  in  NREQ  producer i has a word
- req_data  in  NREQ*DW  producer i word at bits [i*DW +: DW]
- req_ready  out  NREQ  one-hot accept; handshake when req_valid[i] & req_ready[i] at posedge
- clr_cnt  in  1  synchronous clear of all counters
- fifo_FULL  in  1  FIFObuffer FULL
- fifo_WR  out  1  FIFObuffer WR, registered
- fifo_EN  out  1  FIFObuffer EN, registered
- fifo_dataIn  out  DW  FIFObuffer dataIn, registered
- grant_id  out  IW  index of the producer whose word is staged, registered
- accept_cnt  out  NREQ*CW  saturating accepted-word count per producer, registered

## Operation
- FSM states: IDLE (fifo_WR=0), PUSH (fifo_WR=1, word presented), STALL (fifo_WR=1, FULL seen, word held).
- A staged word is written when fifo_WR=1 and fifo_FULL=0 at a posedge.
- can_load = (state==IDLE) | (fifo_WR & ~fifo_FULL). This is combinational on state and fifo_FULL.
- Winner: the first i with req_valid[i]=1, searching from last_grant+1 upward and wrapping modulo NREQ.
- req_ready[winner] = can_load. All other req_ready bits are 0. req_ready is 0 while Rst=0.
- On a handshake:
  - fifo_dataIn <= req_data[winner], fifo_WR <= 1, grant_id <= winner, last_grant <= winner.
  - Next state is PUSH.
- Transitions:
  - IDLE: handshake -> PUSH; otherwise stay IDLE.
  - PUSH/STALL with FULL=0: handshake -> PUSH (back-to-back); no valid -> IDLE with fifo_WR <= 0.
  - PUSH/STALL with FULL=1: go to (or stay in) STALL. fifo_WR, fifo_dataIn and grant_id are held, and req_ready is all 0.
- last_grant updates only on a handshake. A producer that drops valid loses its turn without penalty.
- accept_cnt[i] increments by 1 on each handshake of producer i and saturates at 2^CW-1.
- clr_cnt=1 zeroes all counters. clr_cnt wins over a same-cycle increment, and that word is not counted.
- fifo_EN <= 1 on every cycle with Rst=1.

## Timing
- Reset values (posedge with Rst=0):
  - state=IDLE, fifo_WR=0, fifo_EN=0, fifo_dataIn=0, grant_id=0, accept_cnt=0.
  - last_grant=NREQ-1, so producer 0 has first priority.
- Latency: handshake at edge k -> fifo_WR=1 with the word during cycle k+1 -> written at edge k+1 if FULL=0.
- Throughput: 1 word/cycle while FULL=0 and any req_valid=1.
- FULL rising while in PUSH: the word is not written. It is held in STALL with no loss and no duplication.
- FULL falling: the held word is written at the first edge with FULL=0. A new handshake may occur at that same edge.
- Reset mid-operation: a staged or stalled word is discarded, and fifo_WR=0 from the next cycle. Counters and the round-robin pointer are reset.
- Handshake in the same cycle as clr_cnt: the word is staged normally, and the counter reads 0 afterwards.

## Test plan
- Reset: hold Rst=0 for 2 cycles with all req_valid=1 -> req_ready=0, fifo_WR=0, fifo_EN=0, accept_cnt all 0. After release, producer 0 wins first.
- Round robin: req_valid=4'b1111, req_data[i]=i*16+1..., FULL=0 for 8 cycles -> grant_id sequence 0,1,2,3,0,1,2,3, fifo_WR=1 continuously, accept_cnt=2 each.
- Sparse fairness: only producers 1 and 3 valid -> grants alternate 1,3,1,3. The grant after last_grant=3 goes to 1, skipping 0 and 2.
- Backpressure: single producer streams 1,2,3,4 and FULL=1 for 3 cycles while word 2 is staged -> fifo_dataIn=2 held with req_ready=0. Written sequence 1,2,3,4 with no gaps or duplicates once FULL drops. accept_cnt[0]=4.
- Counter: with CW=4, 20 handshakes from producer 2 -> accept_cnt[2]=15. Then clr_cnt=1 in a handshake cycle -> accept_cnt[2]=0.
- Mid-stream reset: Rst=0 during STALL with data 0xDEAD_BEEF staged -> fifo_WR=0 next cycle. After release the first accepted word comes from producer 0.
